// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave.
//   - htrans encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - hresp OKAY/ERROR values
//   - hsize encodings (log2 of transfer bytes)
//   - slave FSM state enum
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised RAM backing the AHB SRAM slave.
//   clk   : write clock (rising edge)
//   we    : write strobe for the word at addr
//   be    : per-byte lane enables for the write
//   addr  : word index shared by the write and read ports
//   wdata : write data
//   rdata : asynchronous read of the word at addr
// Contents are not reset.
module ahb_sram_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [MEM_AW-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave terminating the bus with an on-chip word RAM.
//   hclk/hresetn : clock, asynchronous active-low reset
//   hsel, haddr, hburst, hsize, htrans, hwrite, hready_in : address phase
//   hwdata       : write data (data phase)
//   hrdata       : read data, driven only in the DATA state, else 0
//   hready       : low during wait states and the first ERROR cycle
//   hresp        : ERROR for the two cycles of an illegal access
// hburst is ignored: every beat is decoded on its own.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hburst,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp
);

  localparam int unsigned NBYTES  = DATA_WIDTH / 8;
  localparam int unsigned BL      = $clog2(NBYTES);
  localparam int unsigned MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned QW      = BL + MEM_AW;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sram_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [QW-1:0]         addr_q;
  logic [2:0]            size_q;
  logic                  write_q;

  logic                  accept, capture, legal;
  logic                  size_ok, align_ok, range_ok;
  logic [ADDR_WIDTH-1:0] align_mask, word_idx;
  logic [NBYTES-1:0]     be;
  logic [BL-1:0]         lane_off;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic unused_hburst;
  assign unused_hburst = ^hburst;

  // Legality of the transfer currently on the address bus.
  always_comb begin
    size_ok    = (hsize <= 3'(BL));
    align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
    align_ok   = ((haddr & align_mask) == '0);
    word_idx   = haddr >> BL;
    range_ok   = (word_idx < ADDR_WIDTH'(MEM_DEPTH));
    legal      = size_ok & align_ok & range_ok;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= haddr[QW-1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    hready  = !(state_q == ST_WAIT || state_q == ST_ERR1);
    hresp   = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    mem_we  = (state_q == ST_DATA) && write_q;
    // Own hready gates acceptance so address changes during a stall are ignored.
    accept  = hsel && hready_in && hready &&
              (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present hready=1 and may take a new transfer.
        state_d = ST_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Lane enables: lanes [off, off + 2^size) of the addressed word.
  always_comb begin
    be       = '0;
    lane_off = addr_q[BL-1:0];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if ((i >= 32'(lane_off)) && (i < 32'(lane_off) + (32'd1 << size_q))) be[i] = 1'b1;
    end
  end

  ahb_sram_slave_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk  (hclk),
    .we   (mem_we),
    .be   (be),
    .addr (addr_q[BL +: MEM_AW]),
    .wdata(hwdata),
    .rdata(mem_rdata)
  );

  assign hrdata = (state_q == ST_DATA) ? mem_rdata : '0;

endmodule
